sr_event_decoder: RTL and testbench
===================================

# sr_event_decoder

Inverse of the SR flip-flop: takes a single level input, filters glitches with a stability counter, and recovers the set/reset events that produced the level. Each accepted edge produces a one-cycle `s_o` (rising) or `r_o` (falling) pulse and a filtered level `q_o`. Each event is also queued into a 2-entry valid/ready event buffer. The block sits between a level source (for example, an SR flip-flop output) and logic that consumes discrete set/reset commands.

## Interface
Parameters:
- `STABLE_CYCLES`, default 3: consecutive sampled cycles `d_i` must differ from `q_o` before an edge is accepted; legal range ≥1.
- `CNT_W`, default 8: width of the accepted-event counter.

Ports:
- `clk_i` in 1: the single clock; all logic is on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `d_i` in 1: level input, already synchronous to `clk_i`.
- `clr_i` in 1: clears `ovf_o` and `evt_cnt_o`.
- `q_o` out 1: filtered level.
- `s_o` out 1: one-cycle pulse on an accepted 0→1 edge.
- `r_o` out 1: one-cycle pulse on an accepted 1→0 edge.
- `evt_valid_o` out 1: event buffer is non-empty.
- `evt_type_o` out 1: head event type; 1 = set, 0 = reset.
- `evt_ready_i` in 1: consumer accepts the head event.
- `ovf_o` out 1: sticky flag; an event was dropped because the buffer was full.
- `evt_cnt_o` out `CNT_W`: saturating count of accepted events, including dropped ones.

## Operation
- States: `LO_IDLE`, `LO_PEND`, `HI_IDLE`, `HI_PEND`. `q_o` = 1 in `HI_*` states.
- In `*_IDLE`, when `d_i != q_o`:
  - `cnt` becomes 1 and the FSM moves to `*_PEND`.
  - If `STABLE_CYCLES` = 1, the edge is accepted immediately instead.
- In `*_PEND`:
  - `d_i == q_o`: `cnt` ← 0, return to `*_IDLE`, no event.
  - `d_i != q_o` and `cnt+1 == STABLE_CYCLES`: accept the edge.
  - Otherwise: `cnt` increments.
- Accepting an edge, at that clock edge:
  - `q_o` flips and the FSM enters the opposite `*_IDLE`.
  - `cnt` ← 0.
  - `s_o` or `r_o` is registered high for exactly one cycle.
  - The event is pushed to the buffer.
  - `evt_cnt_o` increments.
- `s_o` and `r_o` are never high together. Back-to-back pulses are possible only when `STABLE_CYCLES` = 1.
- Buffer: 2-entry FIFO of event type.
  - Pop: `evt_valid_o && evt_ready_i`.
  - Push while full without a same-cycle pop: the event is dropped and `ovf_o` ← 1.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push into an empty buffer: `evt_valid_o` rises the cycle after the accepting edge. There is no bypass.
- `evt_cnt_o` saturates at 2^`CNT_W`−1 and does not wrap.
- `clr_i` has priority at its edge: `evt_cnt_o` ← 0 and `ovf_o` ← 0, even if an event or overflow coincides. A coincident event is still pushed if there is space.
- `rst_i` overrides everything, including mid-`PEND` and a non-empty buffer. Any partially counted stability interval is discarded.

## Timing
- Reset values: `q_o`=0, `s_o`=0, `r_o`=0, `evt_valid_o`=0, `evt_type_o`=0, `ovf_o`=0, `evt_cnt_o`=0. State is `LO_IDLE`, `cnt`=0, buffer empty.
- Latency: `d_i` first sampled changed at edge k and held → `q_o`, the pulse and `evt_valid_o` update at edge k+`STABLE_CYCLES`−1.
- Glitches shorter than `STABLE_CYCLES` samples produce no output change.
- `evt_type_o` is stable while `evt_valid_o`=1 and no pop occurs.
- The FIFO must not drop an event while it has space, regardless of `evt_ready_i` timing.

## Structure
- Shared package `sr_pkg`:
  - state enum `sr_dec_state_t` (4 states).
  - constants `EVT_SET`=1'b1 and `EVT_RESET`=1'b0.
- One sub-module, `sr_evt_fifo`: 2-entry, 1-bit-wide FIFO with push, pop, full, empty and head outputs, and synchronous active-high reset.
- Stability counter width: `$clog2(STABLE_CYCLES+1)`.

## Test plan
All scenarios use `STABLE_CYCLES`=3.
1. Reset with `rst_i`=1 for 2 cycles and `d_i`=1 → all outputs 0 during reset. After release, `d_i` held high → `q_o`=1 and `s_o` pulse at the 3rd sampling edge.
2. `d_i` 0→1 held, `evt_ready_i`=1 → single `s_o` pulse. `evt_valid_o`=1 with `evt_type_o`=1 for one cycle, then 0. `evt_cnt_o`=1.
3. Glitch: `d_i` high for 2 samples, then low → `q_o` stays 0, no pulse, `evt_cnt_o` unchanged, buffer empty.
4. Overflow: `evt_ready_i`=0 and three accepted edges (set, reset, set).
   - Buffer holds set then reset; the third event is dropped.
   - `ovf_o`=1, `evt_cnt_o`=3.
   - Then `clr_i` → `ovf_o`=0 and `evt_cnt_o`=0, buffer unchanged.
5. Buffer full with `evt_ready_i`=1 in the same cycle as a new accepted edge → pop and push both occur. `ovf_o` stays 0 and the buffer stays full with the correct order.
6. Reset mid-operation: `d_i` high for 2 samples, then `rst_i` for 1 cycle → `cnt` cleared. After release, `q_o` rises only after 3 fresh high samples.

Source files
------------

// File: rtl/sr_event_decoder_pkg.sv
// Shared types and constants for the set/reset event decoder.
package sr_pkg;

    typedef enum logic [1:0] {
        LO_IDLE = 2'b00,
        LO_PEND = 2'b01,
        HI_IDLE = 2'b10,
        HI_PEND = 2'b11
    } sr_dec_state_t;

    localparam logic EVT_SET   = 1'b1;
    localparam logic EVT_RESET = 1'b0;

    function automatic logic state_level(input sr_dec_state_t s);
        return (s == HI_IDLE) || (s == HI_PEND);
    endfunction

endpackage

// File: rtl/sr_event_decoder_fifo.sv
// Two-entry, one-bit-wide event FIFO; a pop frees a slot for a same-cycle push.
module sr_evt_fifo (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic push_data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    logic [1:0] mem_q, mem_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       do_push, do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        assign mem_d[gi] = (do_push && (wr_q == 1'(gi))) ? push_data_i : mem_q[gi];
    end

    always_comb begin
        wr_d  = do_push ? ~wr_q : wr_q;
        rd_d  = do_pop  ? ~rd_q : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sr_event_decoder.sv
// Recovers set/reset events from a level input using a stability filter,
// emitting one-cycle pulses and queueing each event into a small buffer.
module sr_event_decoder
    import sr_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             d_i,
    input  logic             clr_i,
    output logic             q_o,
    output logic             s_o,
    output logic             r_o,
    output logic             evt_valid_o,
    output logic             evt_type_o,
    input  logic             evt_ready_i,
    output logic             ovf_o,
    output logic [CNT_W-1:0] evt_cnt_o
);

    localparam int               SC_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sr_dec_state_t    state_q, state_d;
    logic [SC_W-1:0]  cnt_q, cnt_d;
    logic             s_q, s_d, r_q, r_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic             level, differ, accept;
    logic             push, push_type, pop, fifo_full, fifo_empty, fifo_head;

    assign level  = state_level(state_q);
    assign differ = (d_i != level);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= LO_IDLE;
            cnt_q     <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            ovf_q     <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            r_q       <= r_d;
            ovf_q     <= ovf_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    // Next state: count consecutive differing samples until the edge is accepted
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            LO_IDLE, HI_IDLE: begin
                if (differ) begin
                    if (STABLE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d   = SC_W'(1);
                        state_d = level ? HI_PEND : LO_PEND;
                    end
                end
            end
            default: begin
                if (!differ) begin
                    cnt_d   = '0;
                    state_d = level ? HI_IDLE : LO_IDLE;
                end else if (cnt_q + 1'b1 == SC_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        if (accept) begin
            state_d = level ? LO_IDLE : HI_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs, event push and bookkeeping; clear wins over a coincident event
    always_comb begin
        s_d       = accept && !level;
        r_d       = accept && level;
        push      = accept;
        push_type = level ? EVT_RESET : EVT_SET;
        pop       = !fifo_empty && evt_ready_i;
        ovf_d     = ovf_q;
        evt_cnt_d = evt_cnt_q;
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (accept && (evt_cnt_q != CNT_MAX)) begin
            evt_cnt_d = evt_cnt_q + 1'b1;
        end
        if (clr_i) begin
            ovf_d     = 1'b0;
            evt_cnt_d = '0;
        end
    end

    sr_evt_fifo u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_type),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign q_o         = level;
    assign s_o         = s_q;
    assign r_o         = r_q;
    assign evt_valid_o = !fifo_empty;
    assign evt_type_o  = fifo_head;
    assign ovf_o       = ovf_q;
    assign evt_cnt_o   = evt_cnt_q;

endmodule

// File: tb/tb_sr_event_decoder.sv
// Directed bench for sr_event_decoder with STABLE_CYCLES=3; popped events are
// checked against a queue of expected event types.
module tb_sr_event_decoder;

    logic       clk = 1'b0;
    logic       rst_i, d_i, clr_i, evt_ready_i;
    logic       q_o, s_o, r_o, evt_valid_o, evt_type_o, ovf_o;
    logic [7:0] evt_cnt_o;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];
    logic mon_exp;

    always #5 clk = ~clk;

    sr_event_decoder #(.STABLE_CYCLES(3), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .d_i         (d_i),
        .clr_i       (clr_i),
        .q_o         (q_o),
        .s_o         (s_o),
        .r_o         (r_o),
        .evt_valid_o (evt_valid_o),
        .evt_type_o  (evt_type_o),
        .evt_ready_i (evt_ready_i),
        .ovf_o       (ovf_o),
        .evt_cnt_o   (evt_cnt_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d t=%0t", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        d_i = v;
        repeat (n) tick();
    endtask

    // Monitor: every handshake pops the oldest expected event
    always @(negedge clk) begin
        if (!rst_i && evt_valid_o && evt_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got type=%0d want=no event t=%0t", evt_type_o, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_type", int'(evt_type_o), int'(mon_exp));
            end
        end
    end

    initial begin
        rst_i = 1'b1; d_i = 1'b1; clr_i = 1'b0; evt_ready_i = 1'b0;

        // Reset held two cycles with d_i high
        repeat (2) begin
            tick();
            chk("rst_q", int'(q_o), 0);
            chk("rst_sr", int'({s_o, r_o}), 0);
            chk("rst_valid_type", int'({evt_valid_o, evt_type_o}), 0);
            chk("rst_ovf_cnt", int'(ovf_o) + int'(evt_cnt_o), 0);
        end
        rst_i = 1'b0;
        tick(); chk("s1_q_k1", int'(q_o), 0);
        tick(); chk("s1_q_k2", int'(q_o), 0);
        tick(); chk("s1_q_k3", int'(q_o), 1);
        chk("s1_s_pulse", int'(s_o), 1);
        chk("s1_valid", int'(evt_valid_o), 1);
        chk("s1_cnt", int'(evt_cnt_o), 1);
        exp_q.push_back(1'b1);
        evt_ready_i = 1'b1;
        tick();
        chk("s1_s_drop", int'(s_o), 0);
        chk("s1_valid_drained", int'(evt_valid_o), 0);

        // Return low, then clear the count
        hold(1'b0, 3);
        chk("fall_r_pulse", int'({s_o, r_o}), 1);
        chk("fall_q", int'(q_o), 0);
        exp_q.push_back(1'b0);
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        chk("clr_cnt", int'(evt_cnt_o), 0);

        // Single set event consumed immediately
        hold(1'b1, 3);
        chk("s2_s_pulse", int'({s_o, r_o}), 2);
        chk("s2_valid_type", int'({evt_valid_o, evt_type_o}), 3);
        chk("s2_cnt", int'(evt_cnt_o), 1);
        exp_q.push_back(1'b1);
        tick();
        chk("s2_pulse_gone", int'({s_o, r_o}), 0);
        chk("s2_valid_gone", int'(evt_valid_o), 0);
        hold(1'b0, 3);
        exp_q.push_back(1'b0);
        clr_i = 1'b1; tick(); clr_i = 1'b0;

        // Glitch shorter than the stability window
        d_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) d_i = 1'b0;
            tick();
            chk("s3_glitch_qs", int'({q_o, s_o, r_o}), 0);
        end
        chk("s3_cnt", int'(evt_cnt_o), 0);
        chk("s3_empty", int'(evt_valid_o), 0);

        // Overflow: three events with no consumer, third dropped
        evt_ready_i = 1'b0;
        hold(1'b1, 3); exp_q.push_back(1'b1);
        hold(1'b0, 3); exp_q.push_back(1'b0);
        chk("s4_no_ovf_yet", int'(ovf_o), 0);
        hold(1'b1, 3);
        chk("s4_ovf", int'(ovf_o), 1);
        chk("s4_cnt", int'(evt_cnt_o), 3);
        chk("s4_head", int'({evt_valid_o, evt_type_o}), 3);
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        chk("s4_clr_ovf", int'(ovf_o), 0);
        chk("s4_clr_cnt", int'(evt_cnt_o), 0);
        chk("s4_clr_head", int'({evt_valid_o, evt_type_o}), 3);

        // Full buffer: pop and push on the same edge
        hold(1'b0, 2);
        evt_ready_i = 1'b1;
        exp_q.push_back(1'b0);
        tick();
        chk("s5_r_pulse", int'({s_o, r_o}), 1);
        chk("s5_ovf", int'(ovf_o), 0);
        chk("s5_head", int'({evt_valid_o, evt_type_o}), 2);
        tick();
        chk("s5_second", int'({evt_valid_o, evt_type_o}), 2);
        tick();
        chk("s5_drained", int'(evt_valid_o), 0);
        chk("s5_ovf_final", int'(ovf_o), 0);

        // Reset in the middle of a stability interval
        hold(1'b1, 2);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("s6_rst_q", int'(q_o), 0);
        tick(); chk("s6_q_k1", int'(q_o), 0);
        tick(); chk("s6_q_k2", int'(q_o), 0);
        tick(); chk("s6_q_k3", int'(q_o), 1);
        chk("s6_s_pulse", int'(s_o), 1);
        chk("s6_cnt", int'(evt_cnt_o), 1);
        exp_q.push_back(1'b1);
        tick();
        chk("s6_drained", int'(evt_valid_o), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
